// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to the
// synchronous instruction memory and buffers responses for decode.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req, imem_addr            read request and word address to imem
//   imem_rdata                     read data, one cycle after imem_req
//   redirect_valid, redirect_pc    PC change from execute (flushes)
//   instr_valid, instr_ready       valid/ready handshake to decode
//   instr, instr_pc,
//   instr_pc_plus4                 head-of-buffer instruction and its PC
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    // ent0 is always the head; ent1 is the second slot.
    fetch_ent_t  ent0;
    fetch_ent_t  ent1;
    fetch_ent_t  incoming;
    logic [1:0]  count;
    logic        inflight;
    logic [31:0] pc;
    logic [31:0] pc_q;

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  credit_used;
    logic [31:0] redirect_aligned;
    logic [31:0] reset_aligned;

    always_comb begin
        redirect_aligned = redirect_pc & ~32'h3;
        reset_aligned    = RESET_PC & ~32'h3;
        // count + inflight never exceeds 2, so 2 bits suffice.
        credit_used      = count + {1'b0, inflight};
        instr_valid      = !rst && (count != 2'd0) && !redirect_valid;
        pop              = instr_valid && instr_ready;
        // A pop frees a slot this cycle, so issue may reuse that credit.
        issue            = !rst && !redirect_valid &&
                           ((credit_used < 2'd2) || pop);
        push             = inflight && !redirect_valid;
        imem_req         = issue;
        imem_addr        = pc;
        incoming         = '{instr: imem_rdata, pc: pc_q};
        instr            = ent0.instr;
        instr_pc         = ent0.pc;
        instr_pc_plus4   = ent0.pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= reset_aligned;
            pc_q     <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc   <= pc + 32'd4;
                pc_q <= pc;
            end
            if (redirect_valid) begin
                // Flush buffered and in-flight wrong-path fetches.
                count <= 2'd0;
                pc    <= redirect_aligned;
            end else begin
                unique case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) ent0 <= incoming;
                        else               ent1 <= incoming;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        ent0  <= ent1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd2) begin
                            ent0 <= ent1;
                            ent1 <= incoming;
                        end else begin
                            ent0 <= incoming;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-clock MIPS processor, placed between `u_instr_mem` and the decode stage inside `mips_processor`. It owns the program counter and issues word reads to the synchronous instruction memory. A 2-entry buffer absorbs the memory's 1-cycle read latency, so decode stalls never lose an instruction. It presents instructions to decode over a valid/ready handshake and discards wrong-path fetches when execute redirects the PC on a branch or jump.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`, input, 1: processor clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `imem_req`, output, 1: read enable to instruction memory.
- `imem_addr`, output, 32: byte address of the read; bits [1:0] always 0.
- `imem_rdata`, input, 32: read data, valid exactly 1 cycle after the `imem_req` cycle.
- `redirect_valid`, input, 1: execute requests a PC change this cycle.
- `redirect_pc`, input, 32: new PC; bits [1:0] ignored and treated as 0.
- `instr_valid`, output, 1: `instr`, `instr_pc` and `instr_pc_plus4` are valid for decode.
- `instr_ready`, input, 1: decode accepts the instruction this cycle.
- `instr`, output, 32: fetched instruction word.
- `instr_pc`, output, 32: address of `instr`.
- `instr_pc_plus4`, output, 32: `instr_pc + 4`, mod 2^32.

## Operation
- State:
  - `pc` (32-bit): next fetch address.
  - `inflight`: a read was issued last cycle.
  - `fifo`: 2 entries of {instr, pc}, plus a count of 0–2.
- Fetch issue:
  - `imem_req = !rst && !redirect_valid && (count + inflight < 2 || pop)`, where `pop = instr_valid && instr_ready`.
  - `imem_addr = pc`.
  - On issue, `pc <= pc + 4` and `inflight <= 1`; otherwise `inflight <= 0`.
  - `pc` wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Response capture:
  - When `inflight` is 1 and no redirect occurs this cycle, push {`imem_rdata`, address issued} into the fifo.
  - The issued address is held in a `pc_q` register.
  - Push and pop may occur in the same cycle; count is unchanged.
  - The credit rule guarantees a push never occurs when count is 2 and no pop happens.
- Output:
  - `instr_valid = (count != 0) && !redirect_valid`.
  - `instr`, `instr_pc` and `instr_pc_plus4` come from the fifo head.
  - When `instr_ready` is low, outputs hold stable until accepted or flushed.
- Redirect (`redirect_valid` = 1) in cycle N:
  - fifo count is set to 0;
  - any in-flight response arriving in cycle N is dropped;
  - no issue occurs in cycle N;
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The first redirected fetch is issued in cycle N+1.
  - Redirect overrides any pop or push in cycle N.
- Reset:
  - `rst` overrides everything.
  - `pc <= RESET_PC`, count 0, `inflight` 0, fifo data cleared to 0.
- Reset asserted mid-operation discards all buffered and in-flight instructions. The next cycle behaves as the first cycle after reset.

## Timing
- Output values during and right after reset:

  | Output | Value |
  |---|---|
  | `imem_req` | 0 |
  | `imem_addr` | `RESET_PC` |
  | `instr_valid` | 0 |
  | `instr` | 0 |
  | `instr_pc` | 0 |
  | `instr_pc_plus4` | 4 |

- Reset deasserted before edge E0:
  - cycle 0: `imem_req` = 1 at `RESET_PC`;
  - cycle 1: data pushed;
  - cycle 2: `instr_valid` = 1.
- Fetch-to-decode latency is 2 cycles, and redirect-to-`instr_valid` is 3 cycles:
  - redirect in cycle N;
  - issue in N+1;
  - push in N+2;
  - valid in N+3.
- With `instr_ready` held at 1, throughput is 1 instruction per cycle with no bubbles.
- With `instr_ready` at 0, issue stops once count + inflight = 2, so at most 2 instructions are buffered.
- When ready returns to 1, delivery resumes from the head in the same cycle, then continues at 1 per cycle.

## Test plan
- **Reset and stream:** `RESET_PC` = 0, memory word i = 32'h1000_0000+i, ready held at 1.
  - `instr_valid` rises in cycle 2.
  - Instructions 32'h1000_0000, _0001, _0002… arrive on consecutive cycles with `instr_pc` = 0, 4, 8…
- **Stall:** ready at 0 for cycles 2–9.
  - Exactly 2 `imem_req` pulses occur.
  - `instr` holds at 32'h1000_0000 and `instr_pc` at 0.
  - After ready rises, pc 0, 4, 8 are delivered in order with no gaps or duplicates.
- **Redirect:** `redirect_valid` for one cycle with `redirect_pc` = 32'h40 while fifo is full and a read is in flight.
  - `instr_valid` = 0 in that cycle.
  - The next `instr_pc` is 32'h40, valid 3 cycles later.
  - No stale pc appears.
- **Misaligned redirect:** `redirect_pc` = 32'h47.
  - `imem_addr` = 32'h44.
  - `instr_pc` = 32'h44 and `instr_pc_plus4` = 32'h48.
- **Wrap:** `redirect_pc` = 32'hFFFF_FFF8.
  - `instr_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `instr_pc_plus4` = 0 for FFFF_FFFC.
- **Mid-run reset:** assert `rst` for one cycle while streaming with count 2.
  - `instr_valid` = 0 the following cycle.
  - Fetching restarts at `RESET_PC` with the same 2-cycle latency.
